// File: rtl/chan_event_counter.sv
// chan_event_counter: per-channel rising-edge event counters for the 1-to-8 demux outputs, with registered readback.
module chan_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       y,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [7:0]       ovf,
    output logic             multi_err,
    output logic [2:0]       last_ch,
    output logic             evt
);
    logic [7:0]       y_q;
    logic [7:0]       rise;
    logic [7:0]       cnt_en;
    logic [CNT_W-1:0] cnt [8];
    logic [2:0]       hi;
    logic             multi;
    assign rise   = y & ~y_q;
    assign cnt_en = rise & {8{en & ~clr}};
    assign multi  = (y & (y - 8'd1)) != 8'd0;
    always_comb begin
        hi = 3'd0;
        for (int k = 0; k < 8; k++)
            if (cnt_en[k]) hi = 3'(k);
    end
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (clr) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (cnt_en[i]) begin
                    // saturate at all-ones and flag it instead of wrapping
                    if (cnt[i] == {CNT_W{1'b1}}) ovf[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + 1'b1;
                end
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y_q       <= '0;
            rd_cnt    <= '0;
            multi_err <= 1'b0;
            last_ch   <= '0;
            evt       <= 1'b0;
        end else begin
            y_q       <= y;
            rd_cnt    <= cnt[rd_sel];
            multi_err <= clr ? 1'b0 : (multi_err | multi);
            last_ch   <= clr ? 3'd0 : (|cnt_en ? hi : last_ch);
            evt       <= |cnt_en;
        end
endmodule

// File: tb/tb_chan_event_counter.sv
// tb_chan_event_counter: directed scenario tests for chan_event_counter (CNT_W=8).
module tb_chan_event_counter;
    logic       clk;
    logic       rst_n;
    logic [7:0] y;
    logic       en;
    logic       clr;
    logic [2:0] rd_sel;
    logic [7:0] rd_cnt;
    logic [7:0] ovf;
    logic       multi_err;
    logic [2:0] last_ch;
    logic       evt;
    int checks = 0;
    int errors = 0;

    chan_event_counter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .y(y), .en(en), .clr(clr), .rd_sel(rd_sel),
        .rd_cnt(rd_cnt), .ovf(ovf), .multi_err(multi_err), .last_ch(last_ch), .evt(evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch);
        y = 8'h01 << ch;
        step();
        y = 8'h00;
        step();
    endtask

    task automatic rd(input logic [2:0] sel, output logic [7:0] v);
        rd_sel = sel;
        step();
        v = rd_cnt;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; y = 8'h00; en = 1'b0; clr = 1'b0; rd_sel = 3'd0;
        #22 rst_n = 1'b1;
        step();
        checks++; if (rd_cnt !== 8'd0) begin errors++; $display("FAIL reset_rd_cnt got %0d want 0", rd_cnt); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got %h want 00", ovf); end
        checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_multi_err got %b want 0", multi_err); end
        checks++; if (last_ch !== 3'd0) begin errors++; $display("FAIL reset_last_ch got %0d want 0", last_ch); end
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL reset_evt got %b want 0", evt); end
    endtask

    task automatic test_pulses();
        int n = 0;
        en = 1'b1; rd_sel = 3'd0;
        for (int k = 0; k < 3; k++) begin
            y = 8'h01; step(); n += int'(evt);
            y = 8'h00; step(); n += int'(evt);
        end
        checks++; if (rd_cnt !== 8'd3) begin errors++; $display("FAIL pulse_cnt got %0d want 3", rd_cnt); end
        checks++; if (n !== 3) begin errors++; $display("FAIL pulse_evt_count got %0d want 3", n); end
        checks++; if (last_ch !== 3'd0) begin errors++; $display("FAIL pulse_last_ch got %0d want 0", last_ch); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL pulse_ovf got %h want 00", ovf); end
    endtask

    task automatic test_walk();
        logic [7:0] v;
        do_clr();
        for (int k = 0; k < 8; k++) pulse(k);
        for (int k = 0; k < 8; k++) begin
            rd(3'(k), v);
            checks++; if (v !== 8'd1) begin errors++; $display("FAIL walk_cnt%0d got %0d want 1", k, v); end
        end
        checks++; if (last_ch !== 3'd7) begin errors++; $display("FAIL walk_last_ch got %0d want 7", last_ch); end
        checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL walk_multi_err got %b want 0", multi_err); end
    endtask

    task automatic test_multi();
        logic [7:0] v;
        do_clr();
        y = 8'h24; step();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL multi_evt got %b want 1", evt); end
        y = 8'h00; step();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL multi_evt_single got %b want 0", evt); end
        rd(3'd2, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL multi_cnt2 got %0d want 1", v); end
        rd(3'd5, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL multi_cnt5 got %0d want 1", v); end
        rd(3'd4, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL multi_cnt4 got %0d want 0", v); end
        checks++; if (last_ch !== 3'd5) begin errors++; $display("FAIL multi_last_ch got %0d want 5", last_ch); end
        checks++; if (multi_err !== 1'b1) begin errors++; $display("FAIL multi_err_set got %b want 1", multi_err); end
        do_clr();
        rd(3'd2, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL clr_cnt2 got %0d want 0", v); end
        checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL clr_multi_err got %b want 0", multi_err); end
        checks++; if (last_ch !== 3'd0) begin errors++; $display("FAIL clr_last_ch got %0d want 0", last_ch); end
    endtask

    task automatic test_saturate();
        logic [7:0] v;
        do_clr();
        for (int k = 0; k < 255; k++) pulse(3);
        rd(3'd3, v);
        checks++; if (v !== 8'd255) begin errors++; $display("FAIL sat_cnt255 got %0d want 255", v); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL sat_ovf_early got %h want 00", ovf); end
        pulse(3);
        rd(3'd3, v);
        checks++; if (v !== 8'd255) begin errors++; $display("FAIL sat_cnt_hold got %0d want 255", v); end
        checks++; if (ovf !== 8'h08) begin errors++; $display("FAIL sat_ovf got %h want 08", ovf); end
        rd(3'd0, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL sat_other_cnt got %0d want 0", v); end
    endtask

    task automatic test_enable();
        logic [7:0] v;
        int n = 0;
        do_clr();
        en = 1'b0;
        for (int k = 0; k < 4; k++) pulse(6);
        y = 8'h40; step();
        en = 1'b1; step(); n += int'(evt);
        step(); n += int'(evt);
        y = 8'h00; step();
        rd(3'd6, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL en_held_cnt got %0d want 0", v); end
        checks++; if (n !== 0) begin errors++; $display("FAIL en_held_evt got %0d want 0", n); end
        pulse(6);
        rd(3'd6, v);
        checks++; if (v !== 8'd1) begin errors++; $display("FAIL en_fresh_cnt got %0d want 1", v); end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        do_clr();
        for (int k = 0; k < 5; k++) pulse(1);
        rd(3'd1, v);
        checks++; if (v !== 8'd5) begin errors++; $display("FAIL ar_pre_cnt got %0d want 5", v); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rd_cnt !== 8'd0) begin errors++; $display("FAIL ar_rd_cnt got %0d want 0", rd_cnt); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ar_ovf got %h want 00", ovf); end
        checks++; if (last_ch !== 3'd0) begin errors++; $display("FAIL ar_last_ch got %0d want 0", last_ch); end
        y = 8'h02; en = 1'b1;
        #2 rst_n = 1'b1;
        step();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL ar_evt got %b want 1", evt); end
        checks++; if (last_ch !== 3'd1) begin errors++; $display("FAIL ar_last_ch_post got %0d want 1", last_ch); end
        y = 8'h00; step();
        checks++; if (rd_cnt !== 8'd1) begin errors++; $display("FAIL ar_cnt_post got %0d want 1", rd_cnt); end
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_walk();
        test_multi();
        test_saturate();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/chan_event_counter.md
Name: chan_event_counter

Overview:
- Downstream consumer of the 1-to-8 demultiplexer.
- Samples the eight demux outputs on `clk` and detects a rising edge on each channel.
- Keeps one saturating event counter per channel, plus sticky overflow flags and a sticky multi-hot error flag.
- The selected count is read back through a registered index port, so the system can check which destinations the demux routed traffic to, and how often.

Parameters:
- CNT_W, 8, width of each per-channel counter (valid range 2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- y  input  8  demux outputs; bit i = demux output yi; synchronous to clk.
- en  input  1  count enable; edges seen while low are not counted.
- clr  input  1  synchronous clear of counters, ovf, multi_err, last_ch.
- rd_sel  input  3  channel index for readback.
- rd_cnt  output  CNT_W  registered count of channel rd_sel.
- ovf  output  8  sticky per-channel saturation flags.
- multi_err  output  1  sticky; set when more than one y bit is high in one sample.
- last_ch  output  3  index of the most recently counted channel.
- evt  output  1  one-cycle pulse; at least one edge was counted this cycle.

Behaviour:
- Reset (rst_n low, asynchronous) sets these to 0: y_q (8-bit previous sample), all counters, rd_cnt, ovf, multi_err, last_ch, evt.
- Each edge: y_q <= y; rise[i] = y[i] & ~y_q[i], computed from the current y against the previous sample.
- Because y_q resets to 0, a channel already high at reset release counts as a rise at the first edge if en=1.
- Count update, for each i with rise[i] & en & ~clr:
  - if cnt[i] < 2^CNT_W-1, then cnt[i] <= cnt[i]+1;
  - else cnt[i] holds and ovf[i] <= 1.
  - No wrap-around ever.
- Simultaneous rises on several channels are all counted in the same cycle.
- last_ch <= highest index among the counted rises; it holds when nothing is counted.
- evt <= OR of (rise & en) when clr=0, else 0. evt is registered, so it is high in the cycle after the counting edge.
- multi_err <= 1 when popcount(y) > 1 at a sampling edge, regardless of en. Cleared only by clr or reset.
- clr has priority over every increment, flag set and multi_err set in the same cycle.
  - clr clears: all counters, ovf, multi_err, last_ch.
  - y_q still updates during clr, so an edge coincident with clr is lost (not counted later).
- Readback: rd_cnt <= cnt[rd_sel] (pre-update value) at every edge.
  - Latency from the counting edge k to rd_cnt showing the new value is edge k+1.
  - A rd_sel change is visible after one edge.
- en low: y_q keeps tracking y, so a level that stays high does not count when en later rises. Only fresh 0->1 transitions count.
- Falling edges and static levels have no effect.
- Reset asserted mid-operation clears everything immediately, with no clock needed. Counting resumes from 0 after release.

Test Plan:
- Reset, then en=1, pulse y=8'h01 for 1 cycle three times with 0 between; rd_sel=0 -> rd_cnt=3, last_ch=0, evt pulsed 3 times, ovf=0.
- Walk y one-hot 8'h01..8'h80, one channel per 2 cycles, en=1; read each rd_sel 0..7 -> every rd_cnt=1, last_ch=7, multi_err=0.
- y=8'h24 rising together -> cnt[2]=cnt[5]=1, last_ch=5, multi_err=1, single evt pulse; clr for 1 cycle -> all counts 0, multi_err=0.
- CNT_W=8: apply 256 pulses on channel 3 -> rd_cnt=255, ovf=8'h08; other counters 0.
- en=0 while pulsing channel 6 four times; raise en with y[6] held high -> cnt[6]=0. Then one fresh pulse -> 1.
- Mid-run: count channel 1 to 5, assert rst_n=0 between clock edges -> rd_cnt, ovf, last_ch read 0 immediately. Release with y=8'h02 and en=1 -> cnt[1]=1 after the first edge.
